// File: rtl/dcache_req_ctrl_pkg.sv
// Shared types for the memory-stage data-cache request controller.
package dcache_req_ctrl_pkg;

   typedef logic [31:0] word_t;

   // IDLE: nothing issued for the current EX/MEM entry; WAIT: issued, no dhit yet;
   // DONE: access complete, holding until the pipeline advances.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } dreq_state_t;

endpackage

// File: rtl/dcache_req_ctrl_if.sv
// Datapath-to-data-cache handshake: request side driven by the controller, hit/data by the cache.
interface dcache_req_ctrl_if;
   import dcache_req_ctrl_pkg::*;

   logic  dmemREN;
   logic  dmemWEN;
   word_t dmemaddr;
   word_t dmemstore;
   logic  dhit;
   word_t dmemload;

   modport master (
      output dmemREN, dmemWEN, dmemaddr, dmemstore,
      input  dhit, dmemload
   );

   modport slave (
      input  dmemREN, dmemWEN, dmemaddr, dmemstore,
      output dhit, dmemload
   );

endinterface

// File: rtl/dcache_req_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/dcache_req_ctrl.sv
// MEM-stage data-cache request controller: issues the EX/MEM access, stalls until dhit,
// holds load data until the pipeline advances, and tracks the sticky halt plus counters.
module dcache_req_ctrl
   import dcache_req_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                CLK,
   input  logic                nRST,
   input  logic                mem_dREN,
   input  logic                mem_dWEN,
   input  logic                mem_halt,
   input  word_t               mem_addr,
   input  word_t               mem_store,
   input  logic                advance,
   dcache_req_ctrl_if.master   dcif,
   output logic                mem_stall,
   output word_t               wb_dmemload,
   output logic                halt,
   output logic [CNT_W-1:0]    acc_cnt,
   output logic [CNT_W-1:0]    stall_cnt
);

   dreq_state_t state_q, state_d;
   word_t       load_q, load_d;
   logic        halt_q, halt_d;

   logic op;
   logic active;
   logic ren;
   logic wen;

   // Requests are also gated by nRST so the cache sees them drop the moment reset asserts.
   always_comb begin
      op     = (mem_dREN | mem_dWEN) & ~halt_q;
      active = op & (state_q != DONE) & nRST;
      wen    = active & mem_dWEN;
      ren    = active & mem_dREN & ~mem_dWEN;
   end

   assign dcif.dmemREN   = ren;
   assign dcif.dmemWEN   = wen;
   assign dcif.dmemaddr  = mem_addr;
   assign dcif.dmemstore = mem_store;

   assign mem_stall   = active & ~dcif.dhit;
   assign wb_dmemload = (state_q == DONE) ? load_q : dcif.dmemload;
   assign halt        = halt_q;

   always_comb begin
      state_d = state_q;
      load_d  = load_q;
      halt_d  = halt_q;

      unique case (state_q)
         IDLE: begin
            if (active && dcif.dhit) begin
               state_d = advance ? IDLE : DONE;
            end else if (active) begin
               state_d = WAIT;
            end
         end
         // advance during a stall is an upstream error; only dhit can leave WAIT.
         WAIT: begin
            if (dcif.dhit) begin
               state_d = advance ? IDLE : DONE;
            end
         end
         DONE: begin
            if (advance) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (dcif.dhit && ren) begin
         load_d = dcif.dmemload;
      end

      if (mem_halt && advance && !op) begin
         halt_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         load_q  <= '0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         load_q  <= load_d;
         halt_q  <= halt_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_acc_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   (dcif.dhit),
      .count (acc_cnt)
   );

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   (mem_stall),
      .count (stall_cnt)
   );

endmodule

// File: tb/tb_dcache_req_ctrl.sv
// Directed bench for dcache_req_ctrl: combinational vector table plus multi-cycle sequences.
module tb_dcache_req_ctrl;
   import dcache_req_ctrl_pkg::*;

   localparam int CNT_W = 3;

   logic             CLK = 1'b0;
   logic             nRST;
   logic             mem_dREN, mem_dWEN, mem_halt, advance;
   word_t            mem_addr, mem_store;
   logic             mem_stall, halt;
   word_t            wb_dmemload;
   logic [CNT_W-1:0] acc_cnt, stall_cnt;

   int tests = 0;
   int fails = 0;

   dcache_req_ctrl_if dcif ();

   dcache_req_ctrl #(.CNT_W(CNT_W)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .mem_dREN    (mem_dREN),
      .mem_dWEN    (mem_dWEN),
      .mem_halt    (mem_halt),
      .mem_addr    (mem_addr),
      .mem_store   (mem_store),
      .advance     (advance),
      .dcif        (dcif.master),
      .mem_stall   (mem_stall),
      .wb_dmemload (wb_dmemload),
      .halt        (halt),
      .acc_cnt     (acc_cnt),
      .stall_cnt   (stall_cnt)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string name;
      logic  ren, wen, hlt;
      word_t addr, store;
      logic  hit;
      word_t load;
      logic  e_ren, e_wen, e_stall;
      word_t e_wb;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic ren, input logic wen, input logic hlt, input word_t addr,
                        input word_t store, input logic hit, input word_t load, input logic adv);
      mem_dREN      = ren;
      mem_dWEN      = wen;
      mem_halt      = hlt;
      mem_addr      = addr;
      mem_store     = store;
      dcif.dhit     = hit;
      dcif.dmemload = load;
      advance       = adv;
   endtask

   task automatic idle_inputs();
      drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      vecs[0] = '{"lw_miss",  1,0,0, 32'h0000_0010, 32'h0, 0, 32'h1111_1111, 1,0,1, 32'h1111_1111};
      vecs[1] = '{"lw_hit",   1,0,0, 32'h0000_0014, 32'h0, 1, 32'h2222_2222, 1,0,0, 32'h2222_2222};
      vecs[2] = '{"sw_hit",   0,1,0, 32'h0000_0018, 32'hA5A5_A5A5, 1, 32'h0, 0,1,0, 32'h0};
      vecs[3] = '{"sw_miss",  0,1,0, 32'h0000_001C, 32'h5A5A_5A5A, 0, 32'h3, 0,1,1, 32'h3};
      vecs[4] = '{"both_set", 1,1,0, 32'h0000_0020, 32'h7777_0000, 0, 32'h0, 0,1,1, 32'h0};
      vecs[5] = '{"no_op",    0,0,0, 32'h0000_0024, 32'h0, 0, 32'h4444_4444, 0,0,0, 32'h4444_4444};
      vecs[6] = '{"halt_fld", 0,0,1, 32'h0000_0028, 32'h0, 0, 32'h0, 0,0,0, 32'h0};

      nRST = 1'b0;
      idle_inputs();
      #2;
      chk("rst_halt",      halt, 0);
      chk("rst_acc",       acc_cnt, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_ren",       dcif.dmemREN, 0);
      chk("rst_wen",       dcif.dmemWEN, 0);
      chk("rst_stall",     mem_stall, 0);
      @(negedge CLK);
      nRST = 1'b1;

      // Single-cycle combinational checks from IDLE; inputs return to idle before each edge.
      for (int i = 0; i < 7; i++) begin
         @(negedge CLK);
         drive(vecs[i].ren, vecs[i].wen, vecs[i].hlt, vecs[i].addr, vecs[i].store,
               vecs[i].hit, vecs[i].load, 1'b0);
         #2;
         chk({vecs[i].name, "_ren"},   dcif.dmemREN, vecs[i].e_ren);
         chk({vecs[i].name, "_wen"},   dcif.dmemWEN, vecs[i].e_wen);
         chk({vecs[i].name, "_stall"}, mem_stall, vecs[i].e_stall);
         chk({vecs[i].name, "_wb"},    wb_dmemload, vecs[i].e_wb);
         chk({vecs[i].name, "_addr"},  dcif.dmemaddr, vecs[i].addr);
         chk({vecs[i].name, "_store"}, dcif.dmemstore, vecs[i].store);
         idle_inputs();
      end

      // Reset asserted while waiting on a miss.
      @(negedge CLK);
      drive(1, 0, 0, 32'h40, 0, 0, 0, 0);
      @(negedge CLK);
      #2;
      chk("wait_stall", mem_stall, 1);
      nRST = 1'b0;
      #1;
      chk("rstwait_ren",   dcif.dmemREN, 0);
      chk("rstwait_halt",  halt, 0);
      chk("rstwait_acc",   acc_cnt, 0);
      chk("rstwait_stcnt", stall_cnt, 0);
      idle_inputs();
      @(negedge CLK);
      nRST = 1'b1;

      // lw 0x100 with a three-cycle miss.
      @(negedge CLK);
      drive(1, 0, 0, 32'h100, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         #2;
         chk("miss_stall", mem_stall, 1);
         @(negedge CLK);
      end
      drive(1, 0, 0, 32'h100, 0, 1, 32'hDEADBEEF, 1);
      #2;
      chk("miss_hit_stall", mem_stall, 0);
      chk("miss_hit_ren",   dcif.dmemREN, 1);
      chk("miss_hit_wb",    wb_dmemload, 32'hDEADBEEF);
      chk("miss_stcnt",     stall_cnt, 3);
      @(negedge CLK);
      idle_inputs();
      #2;
      chk("miss_acc", acc_cnt, 1);

      // sw 0x200 hits at once while the pipeline is frozen for two more cycles.
      @(negedge CLK);
      drive(0, 1, 0, 32'h200, 32'h12345678, 1, 0, 0);
      #2;
      chk("sw_wen",   dcif.dmemWEN, 1);
      chk("sw_stall", mem_stall, 0);
      chk("sw_addr",  dcif.dmemaddr, 32'h200);
      chk("sw_data",  dcif.dmemstore, 32'h12345678);
      for (int k = 0; k < 2; k++) begin
         @(negedge CLK);
         drive(0, 1, 0, 32'h200, 32'h12345678, 0, 0, 0);
         #2;
         chk("sw_done_wen",   dcif.dmemWEN, 0);
         chk("sw_done_stall", mem_stall, 0);
         chk("sw_done_acc",   acc_cnt, 2);
      end
      @(negedge CLK);
      drive(0, 1, 0, 32'h200, 32'h12345678, 0, 0, 1);
      #2;
      chk("sw_adv_wen", dcif.dmemWEN, 0);
      @(negedge CLK);
      idle_inputs();
      #2;
      chk("sw_acc", acc_cnt, 2);

      // lw hits with advance low: load word must be held through DONE.
      @(negedge CLK);
      drive(1, 0, 0, 32'h300, 0, 1, 32'hCAFEF00D, 0);
      #2;
      chk("hold_wb0", wb_dmemload, 32'hCAFEF00D);
      @(negedge CLK);
      drive(1, 0, 0, 32'h300, 0, 0, 32'h0, 0);
      #2;
      chk("hold_wb1",   wb_dmemload, 32'hCAFEF00D);
      chk("hold_ren",   dcif.dmemREN, 0);
      chk("hold_stall", mem_stall, 0);
      @(negedge CLK);
      drive(1, 0, 0, 32'h300, 0, 0, 32'h0, 1);
      #2;
      chk("hold_wb2", wb_dmemload, 32'hCAFEF00D);
      @(negedge CLK);
      drive(1, 0, 0, 32'h304, 0, 1, 32'h11, 1);
      #2;
      chk("b2b_ren", dcif.dmemREN, 1);
      chk("b2b_wb",  wb_dmemload, 32'h11);
      @(negedge CLK);
      idle_inputs();
      #2;
      chk("b2b_acc", acc_cnt, 4);

      // Halt entry, then a load that must never issue.
      @(negedge CLK);
      drive(0, 0, 1, 0, 0, 0, 0, 1);
      #2;
      chk("halt_pre", halt, 0);
      @(negedge CLK);
      drive(1, 0, 0, 32'h400, 0, 0, 0, 0);
      #2;
      chk("halt_set",   halt, 1);
      chk("halt_ren",   dcif.dmemREN, 0);
      chk("halt_stall", mem_stall, 0);
      repeat (3) @(negedge CLK);
      #2;
      chk("halt_stcnt", stall_cnt, 3);
      chk("halt_held",  halt, 1);

      // acc_cnt saturation: four more hits from 4 must stop at 7.
      @(negedge CLK);
      dcif.dhit = 1'b1;
      repeat (4) @(negedge CLK);
      #2;
      chk("acc_sat", acc_cnt, 7);
      idle_inputs();

      // stall_cnt saturation after a fresh reset.
      nRST = 1'b0;
      #1;
      chk("rst2_halt", halt, 0);
      chk("rst2_acc",  acc_cnt, 0);
      @(negedge CLK);
      nRST = 1'b1;
      drive(1, 0, 0, 32'h500, 0, 0, 0, 0);
      repeat (9) @(negedge CLK);
      #2;
      chk("stall_sat",   stall_cnt, 7);
      chk("stall_still", mem_stall, 1);
      idle_inputs();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
